// File: rtl/l2_port_responder.sv
// L2 responder for one L1 cache port: page fills on reads, write-through on
// writes, and forwarding of peer-core writes to the L1 as invalidations.
module l2_port_responder #(
  parameter int is_inst = 0,
  parameter int num     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c_l2_valid,
  input  logic         c_l2_rd_wr,
  input  logic [13:0]  c_l2_addr,
  input  logic [31:0]  c_l2_din,
  output logic         c_l2_page_wr,
  output logic [127:0] c_l2_page_dout,
  output logic         c_l2_wr_ack,
  output logic         c_dirty,
  output logic [13:0]  c_dirty_addr,
  input  logic         mem_gnt,
  output logic         mem_en,
  output logic         mem_we,
  output logic [13:0]  mem_addr,
  output logic [31:0]  mem_din,
  input  logic [31:0]  mem_dout,
  input  logic         peer_wr_valid,
  input  logic [13:0]  peer_wr_addr,
  output logic         own_wr_valid,
  output logic [13:0]  own_wr_addr,
  output logic [1:0]   own_wr_src
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_RESP, S_HOLD} state_t;

  localparam logic LP_INST = (is_inst != 0);

  state_t         r_state;
  logic [13:0]    r_addr;
  logic [2:0]     r_iss;
  logic [2:0]     r_cap;
  logic           r_pend;
  logic [127:0]   r_buf;
  logic           r_page_wr;
  logic [127:0]   r_page_dout;
  logic           r_wr_ack;
  logic           r_dirty;
  logic [13:0]    r_dirty_addr;
  logic           r_mem_en;
  logic           r_mem_we;
  logic [13:0]    r_mem_addr;
  logic [31:0]    r_mem_din;
  logic           r_own_wr_valid;
  logic [13:0]    r_own_wr_addr;

  logic           w_is_read;
  logic           w_grant;
  logic           w_collide;
  logic [127:0]   w_buf_next;

  // Instruction ports treat every request as a read.
  assign w_is_read = LP_INST | ~c_l2_rd_wr;
  assign w_grant   = r_mem_en & mem_gnt;
  // A peer write into the page being filled makes the partial fill stale.
  assign w_collide = (r_state == S_FILL) && peer_wr_valid &&
                     (peer_wr_addr[13:2] == r_addr[13:2]);

  // Fill buffer with the returning memory word merged into the current slot.
  always_comb begin
    w_buf_next = r_buf;
    case (r_cap[1:0])
      2'd0:    w_buf_next[31:0]   = mem_dout;
      2'd1:    w_buf_next[63:32]  = mem_dout;
      2'd2:    w_buf_next[95:64]  = mem_dout;
      default: w_buf_next[127:96] = mem_dout;
    endcase
  end

  // Request FSM: accepts a request, runs the fill or write, responds, then
  // spends one HOLD cycle so a still-asserted request is not taken twice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_iss          <= '0;
      r_cap          <= '0;
      r_pend         <= 1'b0;
      r_buf          <= '0;
      r_page_wr      <= 1'b0;
      r_page_dout    <= '0;
      r_wr_ack       <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_din      <= '0;
      r_own_wr_valid <= 1'b0;
      r_own_wr_addr  <= '0;
    end else begin
      r_page_wr      <= 1'b0;
      r_wr_ack       <= 1'b0;
      r_own_wr_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (c_l2_valid) begin
            r_addr   <= c_l2_addr;
            r_mem_en <= 1'b1;
            if (w_is_read) begin
              r_iss      <= '0;
              r_cap      <= '0;
              r_pend     <= 1'b0;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {c_l2_addr[13:2], 2'b00};
              r_state    <= S_FILL;
            end else begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= c_l2_addr;
              r_mem_din  <= c_l2_din;
              r_state    <= S_WRITE;
            end
          end
        end
        S_FILL: begin
          if (w_collide) begin
            // Restart from word 0; whatever read is in flight is dropped.
            r_iss      <= '0;
            r_cap      <= '0;
            r_pend     <= 1'b0;
            r_mem_en   <= 1'b1;
            r_mem_addr <= {r_addr[13:2], 2'b00};
          end else begin
            r_pend <= w_grant;
            if (w_grant) begin
              r_iss <= r_iss + 3'd1;
              if (r_iss == 3'd3) begin
                r_mem_en <= 1'b0;
              end else begin
                r_mem_addr <= {r_addr[13:2], r_iss[1:0] + 2'd1};
              end
            end
            if (r_pend) begin
              r_buf <= w_buf_next;
              r_cap <= r_cap + 3'd1;
              if (r_cap == 3'd3) begin
                // Page output only changes once a complete page is in hand.
                r_page_dout <= w_buf_next;
                r_page_wr   <= 1'b1;
                r_state     <= S_RESP;
              end
            end
          end
        end
        S_WRITE: begin
          if (mem_gnt) begin
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_wr_ack       <= 1'b1;
            r_own_wr_valid <= 1'b1;
            r_own_wr_addr  <= r_addr;
            r_state        <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_HOLD;
        S_HOLD:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Peer write notifications become L1 invalidations one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dirty      <= 1'b0;
      r_dirty_addr <= '0;
    end else begin
      r_dirty <= peer_wr_valid;
      if (peer_wr_valid) begin
        r_dirty_addr <= peer_wr_addr;
      end
    end
  end

  assign c_l2_page_wr   = r_page_wr;
  assign c_l2_page_dout = r_page_dout;
  assign c_l2_wr_ack    = r_wr_ack;
  assign c_dirty        = r_dirty;
  assign c_dirty_addr   = r_dirty_addr;
  assign mem_en         = r_mem_en;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_din        = r_mem_din;
  assign own_wr_valid   = r_own_wr_valid;
  assign own_wr_addr    = r_own_wr_addr;
  assign own_wr_src     = 2'(num);

endmodule

// File: doc/l2_port_responder.md
# l2_port_responder

- Responder end of the L1↔L2 port used by each core's data and instruction caches.
- Accepts single-word requests from one `cache_l1` instance and answers reads with a 128-bit page fill (`c_l2_page_wr`/`c_l2_page_dout`).
- Answers writes with a write-through to backing memory plus a `c_l2_wr_ack` pulse.
- Forwards peer-core write notifications to its L1 as `c_dirty`/`c_dirty_addr` invalidations.
- One instance sits per L1 port inside the L2 subsystem, between the core's cache and the shared backing-memory arbiter.

## Interface
Parameters:
- `is_inst`, 0: when 1 (instruction port), `c_l2_rd_wr` is ignored, every request is a read, and `c_l2_wr_ack`/`own_wr_valid` are never asserted.
- `num`, 1: core index; driven unchanged on `own_wr_src`.

Ports (reset is asynchronous, active-low, named `rst`; single clock `clk`):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous active-low reset.
- `c_l2_valid` in 1: L1 request valid, held until response.
- `c_l2_rd_wr` in 1: 0 = read page, 1 = write word.
- `c_l2_addr` in 14: word address.
- `c_l2_din` in 32: write data.
- `c_l2_page_wr` out 1: one-cycle page-fill strobe.
- `c_l2_page_dout` out 128: page data, word k at bits [32k+31:32k].
- `c_l2_wr_ack` out 1: one-cycle write acknowledge.
- `c_dirty` out 1: one-cycle invalidate strobe to L1.
- `c_dirty_addr` out 14: invalidated word address.
- `mem_gnt` in 1: backing memory grants an access this cycle.
- `mem_en` out 1: memory access request.
- `mem_we` out 1: memory write.
- `mem_addr` out 14: memory word address.
- `mem_din` out 32: memory write data.
- `mem_dout` in 32: read data, valid the cycle after a granted read.
- `peer_wr_valid` in 1: a peer core completed a write.
- `peer_wr_addr` in 14: peer write address.
- `own_wr_valid` out 1: this port completed a write (to peers).
- `own_wr_addr` out 14: that address.
- `own_wr_src` out 2: constant `num`.

## Operation
- **States:** IDLE, FILL, WRITE, RESP, HOLD.
- **Reset:** all outputs 0; `c_l2_page_dout` 0; state IDLE.
- **IDLE:**
  - Request fields are registered on `c_l2_valid`=1.
  - If `rd_wr`=0, or `is_inst`=1, go to FILL. Base = `addr[13:2]`, issue count 0, capture count 0.
  - Otherwise go to WRITE.
- **FILL:**
  - `mem_en`=1, `mem_we`=0, `mem_addr`={base, issue count}, while issue count < 4.
  - Issue count increments only in cycles with `mem_gnt`=1.
  - The cycle after each granted read, capture `mem_dout` into word slot = capture count, then increment capture count.
  - After the 4th capture, go to RESP.
- **WRITE:**
  - `mem_en`=1, `mem_we`=1, `mem_addr`=`addr`, `mem_din`=`din`, held until `mem_gnt`=1, then go to RESP.
- **RESP (one cycle):**
  - After a fill: `c_l2_page_wr`=1.
  - After a write: `c_l2_wr_ack`=1, `own_wr_valid`=1, `own_wr_addr`=`addr`.
  - Then go to HOLD.
- **HOLD (one cycle):** `c_l2_valid` is ignored, so a held request is not re-captured. Then go to IDLE.
- **Peer invalidation:**
  - `peer_wr_valid` produces `c_dirty`=1 with `c_dirty_addr`=`peer_wr_addr` one cycle later, in every state.
  - Back-to-back peer writes produce back-to-back strobes.
- **Fill collision:**
  - Applies when `peer_wr_valid` arrives in FILL with `peer_wr_addr[13:2]`=base.
  - The fill restarts: both counts reset to 0 the next cycle, and any read in flight is discarded.
  - The page is delivered only after 4 clean captures.
- **Write/peer same cycle:** no interaction; the own write completes normally.
- **Reset mid-operation:** everything is dropped immediately with no response; the L1 must re-request.

## Timing
- Request sampled in cycle T, with `mem_gnt` held at 1:
  - Read: memory issues at T+1..T+4, captures at T+2..T+5, `c_l2_page_wr` at T+6, next accept at T+8.
  - Write: `mem_en`/`mem_we` at T+1, `c_l2_wr_ack` at T+2, next accept at T+4.
- Each `mem_gnt`=0 cycle during an issue adds exactly one cycle.
- `c_l2_page_dout` holds from RESP until the next fill completes.
- `c_dirty` latency from `peer_wr_valid` is exactly 1 cycle.

## Test plan
- Read `addr`=0x0105 with memory words 0x104..0x107 = A0..A3, `mem_gnt`=1:
  - Reads issued to 0x104..0x107.
  - `c_l2_page_wr` at T+6 with `page_dout`={A3,A2,A1,A0}.
- Write `addr`=0x0020, `din`=0xDEADBEEF:
  - `mem_we` at 0x0020 at T+1.
  - `c_l2_wr_ack`, `own_wr_valid`, and `own_wr_addr`=0x0020 at T+2.
  - A subsequent read of page 0x008 returns 0xDEADBEEF in word 0.
- `mem_gnt` toggling 1,0,1,0… during a fill: page data still correct, `page_wr` at T+9.
- During a fill of page 0x041, `peer_wr_valid` with `addr` 0x0106:
  - `c_dirty`=1 with `c_dirty_addr`=0x0106 next cycle.
  - The fill restarts and the page carries post-write data.
- `is_inst`=1, request with `rd_wr`=1: performed as a read, no `wr_ack`; `c_l2_valid` held through HOLD gives exactly one `page_wr`.
- `rst` low during FILL: all outputs 0 at once, no `page_wr`; a new request after release completes normally.
